// File: rtl/prox_ranging_scheduler.sv
// Round-robin ultrasonic ranger sequencer: fires one sensor at a time, times its echo, publishes results and crash flags.
// Optional macro PROX_CRASH_DEBOUNCE_EN: a crash flag sets only after two consecutive near readings from that sensor.
module prox_ranging_scheduler #(
  parameter int NUM_SENSORS    = 2,
  parameter int CNT_W          = 32,
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int GAP_CYCLES     = 1000000,
  parameter int CRASH_THRESH   = 294117,
  localparam int ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trigger,
  output logic [CNT_W-1:0]       result_cycles,
  output logic [ID_W-1:0]        result_id,
  output logic                   result_valid,
  output logic                   result_timeout,
  output logic [NUM_SENSORS-1:0] crash_vec,
  output logic                   is_crash
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH_C     = CNT_W'(CRASH_THRESH);
  localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(NUM_SENSORS - 1);

  state_t                 state;
  logic [ID_W-1:0]        cur_id;
  logic [ID_W-1:0]        next_id;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_SENSORS-1:0] echo_meta;
  logic [NUM_SENSORS-1:0] echo_sync;
  logic                   echo_cur;
  logic                   emit;
  logic                   emit_timeout;
  logic                   emit_near;
  logic [CNT_W-1:0]       emit_cycles;
  logic [NUM_SENSORS-1:0] crash_next;
`ifdef PROX_CRASH_DEBOUNCE_EN
  logic [NUM_SENSORS-1:0] near_hist;
  logic [NUM_SENSORS-1:0] hist_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  assign echo_cur = echo_sync[cur_id];
  assign next_id  = (cur_id == LAST_ID) ? '0 : cur_id + ID_W'(1);

  // A ping ends on echo fall, on a missing rise, or on a saturated echo width.
  always_comb begin
    emit         = 1'b0;
    emit_timeout = 1'b0;
    emit_cycles  = '0;
    case (state)
      S_WAIT_RISE: begin
        if (!echo_cur && cnt >= TIMEOUT_LAST) begin
          emit         = 1'b1;
          emit_timeout = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!echo_cur) begin
          emit        = 1'b1;
          emit_cycles = cnt;
        end else if (cnt >= TIMEOUT_LAST) begin
          emit         = 1'b1;
          emit_timeout = 1'b1;
          emit_cycles  = TIMEOUT_C;
        end
      end
      default: ;
    endcase
  end

  assign emit_near = !emit_timeout && (emit_cycles != '0) && (emit_cycles <= THRESH_C);

  always_comb begin
    crash_next = crash_vec;
`ifdef PROX_CRASH_DEBOUNCE_EN
    hist_next = near_hist;
    if (emit) begin
      crash_next[cur_id] = emit_near & near_hist[cur_id];
      hist_next[cur_id]  = emit_near;
    end
`else
    if (emit) crash_next[cur_id] = emit_near;
`endif
  end

  // result_valid is a bare one-cycle strobe with no back-pressure; the result fields hold until the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cur_id         <= '0;
      cnt            <= '0;
      trigger        <= '0;
      result_cycles  <= '0;
      result_id      <= '0;
      result_valid   <= 1'b0;
      result_timeout <= 1'b0;
      crash_vec      <= '0;
      is_crash       <= 1'b0;
`ifdef PROX_CRASH_DEBOUNCE_EN
      near_hist      <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      is_crash     <= |crash_vec;
      if (emit) begin
        result_valid   <= 1'b1;
        result_cycles  <= emit_cycles;
        result_id      <= cur_id;
        result_timeout <= emit_timeout;
        crash_vec      <= crash_next;
`ifdef PROX_CRASH_DEBOUNCE_EN
        near_hist      <= hist_next;
`endif
      end
      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_TRIG;
            cnt     <= '0;
            trigger <= NUM_SENSORS'(1) << cur_id;
          end
        end
        S_TRIG: begin
          if (cnt >= TRIG_LAST) begin
            trigger <= '0;
            cnt     <= '0;
            state   <= S_WAIT_RISE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_RISE: begin
          if (echo_cur) begin
            cnt   <= CNT_W'(1);
            state <= S_MEASURE;
          end else if (emit) begin
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_MEASURE: begin
          if (emit) begin
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          // A sensor whose echo is still high is never re-fired, so the gap stretches until it falls.
          if (cnt >= GAP_LAST && !echo_cur) begin
            cur_id <= next_id;
            cnt    <= '0;
            if (enable) begin
              state   <= S_TRIG;
              trigger <= NUM_SENSORS'(1) << next_id;
            end else begin
              state <= S_IDLE;
            end
          end else if (cnt < GAP_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prox_ranging_scheduler.sv
// Bench for prox_ranging_scheduler: table vectors, random pings against a ping-level model, and hand-written corner sequences.
module tb_prox_ranging_scheduler;
  localparam int NS    = 2;
  localparam int CW    = 32;
  localparam int TRIG  = 10;
  localparam int TMO   = 200;
  localparam int GAP   = 50;
  localparam int THR   = 100;
  localparam int RES_W = NS + 1 + 1 + CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NS-1:0] echo;
  logic [NS-1:0] trigger;
  logic [CW-1:0] result_cycles;
  logic [0:0]    result_id;
  logic          result_valid;
  logic          result_timeout;
  logic [NS-1:0] crash_vec;
  logic          is_crash;

  prox_ranging_scheduler #(
    .NUM_SENSORS(NS), .CNT_W(CW), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES(GAP), .CRASH_THRESH(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trigger(trigger),
    .result_cycles(result_cycles), .result_id(result_id), .result_valid(result_valid),
    .result_timeout(result_timeout), .crash_vec(crash_vec), .is_crash(is_crash)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [RES_W-1:0] exp_q[$];
  logic [NS-1:0] crash_m = '0;
  logic [NS-1:0] hist_m  = '0;
  int next_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic abort_run(input string name);
    total++;
    bad++;
    $display("FAIL %s: awaited DUT event did not occur within bound", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // reference model: ping outcome from echo width, crash flags from the result stream
  function automatic void model_of(input int w, output int cyc, output logic to);
    if (w == 0) begin
      cyc = 0;
      to  = 1'b1;
    end else if (w >= TMO) begin
      cyc = TMO;
      to  = 1'b1;
    end else begin
      cyc = w;
      to  = 1'b0;
    end
  endfunction

  task automatic push_result(input int id, input int cyc, input logic to);
    logic near;
    near = !to && cyc > 0 && cyc <= THR;
`ifdef PROX_CRASH_DEBOUNCE_EN
    crash_m[id] = near && hist_m[id];
    hist_m[id]  = near;
`else
    crash_m[id] = near;
`endif
    exp_q.push_back({crash_m, id[0], to, cyc[CW-1:0]});
  endtask

  // scoreboard / monitor
  int               run_len    = 0;
  int               fire_cnt   = 0;
  logic [NS-1:0]    run_bits   = '0;
  logic             prev_valid = 1'b0;
  logic             chk_crash  = 1'b0;
  logic [NS-1:0]    last_crash = '0;
  logic [RES_W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len    = 0;
      fire_cnt   = 0;
      prev_valid = 1'b0;
      chk_crash  = 1'b0;
    end else begin
      if (chk_crash) begin
        chk("is_crash", is_crash, |last_crash);
        chk_crash = 1'b0;
      end
      if (result_valid) begin
        chk("valid_one_cycle", prev_valid, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got id=%0d cycles=%0d required no result", result_id, result_cycles);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_id", result_id, mon_e[CW+1]);
          chk("result_timeout", result_timeout, mon_e[CW]);
          chk("result_cycles", result_cycles, mon_e[CW-1:0]);
          chk("crash_vec", crash_vec, mon_e[RES_W-1 -: NS]);
          last_crash = mon_e[RES_W-1 -: NS];
          chk_crash  = 1'b1;
        end
      end
      prev_valid = result_valid;
      if (trigger != '0) begin
        chk("trig_onehot", $onehot(trigger), 1);
        if (run_len == 0) run_bits = trigger;
        else chk("trig_stable", trigger, run_bits);
        run_len++;
      end else if (run_len != 0) begin
        chk("trig_len", run_len, TRIG);
        chk("trig_order", run_bits, NS'(1) << (fire_cnt % NS));
        fire_cnt++;
        run_len = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_trig_rise(input int budget);
    int n;
    n = 0;
    while (trigger == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (trigger == '0) abort_run("trig_rise_timeout");
  endtask

  task automatic wait_trig_fall();
    int n;
    n = 0;
    while (trigger != '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (trigger != '0) abort_run("trig_fall_timeout");
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) abort_run("result_drain_timeout");
  endtask

  task automatic ping_body(input int id, input int w, input int cyc, input logic to);
    int d, other, n;
    wait_trig_fall();
    other = (id + 1) % NS;
    push_result(id, cyc, to);
    echo[other] = 1'($urandom_range(0, 1));
    if (w == 0) begin
      n = 0;
      while (!result_valid && n < 2 * TMO) begin
        @(negedge clk);
        n++;
        if (n == 30) echo[other] = 1'b0;
      end
      chk("norise_latency", n, TMO);
    end else begin
      d = $urandom_range(0, 20);
      repeat (d) @(negedge clk);
      echo[id] = 1'b1;
      repeat (w) @(negedge clk);
      echo[id] = 1'b0;
    end
    echo[other] = 1'b0;
  endtask

  task automatic ping(input int w, input int cyc, input logic to);
    int id;
    wait_trig_rise(1000);
    id = next_id;
    next_id = (next_id + 1) % NS;
    ping_body(id, w, cyc, to);
  endtask

  typedef struct {
    int   w;
    int   cyc;
    logic to;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int   w, cyc, id, n, trig_seen;
    logic to;

    tbl[0]  = '{80, 80, 1'b0};
    tbl[1]  = '{150, 150, 1'b0};
    tbl[2]  = '{150, 150, 1'b0};
    tbl[3]  = '{0, 0, 1'b1};
    tbl[4]  = '{100, 100, 1'b0};
    tbl[5]  = '{101, 101, 1'b0};
    tbl[6]  = '{1, 1, 1'b0};
    tbl[7]  = '{50, 50, 1'b0};
    tbl[8]  = '{199, 199, 1'b0};
    tbl[9]  = '{200, 200, 1'b1};
    tbl[10] = '{230, 200, 1'b1};

    rst_n  = 1'b0;
    enable = 1'b0;
    echo   = '0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", trigger, 0);
    chk("rst_result_cycles", result_cycles, 0);
    chk("rst_result_id", result_id, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_timeout", result_timeout, 0);
    chk("rst_crash_vec", crash_vec, 0);
    chk("rst_is_crash", is_crash, 0);
    rst_n = 1'b1;
    trig_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (trigger != '0) trig_seen++;
    end
    chk("idle_no_trigger", trig_seen, 0);

    enable = 1'b1;
    for (int i = 0; i < 11; i++) ping(tbl[i].w, tbl[i].cyc, tbl[i].to);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 9))
        0:       w = 0;
        1:       w = $urandom_range(TMO, TMO + 40);
        default: w = $urandom_range(1, TMO - 1);
      endcase
      model_of(w, cyc, to);
      ping(w, cyc, to);
    end

    // stuck echo on sensor 0: saturated result, gap stretches until the echo falls
    if (next_id != 0) ping(30, 30, 1'b0);
    wait_trig_rise(1000);
    next_id = 1;
    wait_trig_fall();
    push_result(0, TMO, 1'b1);
    echo[0] = 1'b1;
    trig_seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (trigger != '0) trig_seen++;
    end
    echo[0] = 1'b0;
    chk("stuck_no_refire", trig_seen, 0);
    n = 0;
    while (trigger == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("refire_sensor1", trigger, 2'b10);
    chk("refire_delay_ok", (n >= 2 && n <= 4), 1);
    next_id = 0;
    ping_body(1, 20, 20, 1'b0);

    // enable dropped mid-measure: result still published, then park in IDLE
    wait_trig_rise(1000);
    id = next_id;
    next_id = (next_id + 1) % NS;
    wait_trig_fall();
    push_result(id, 60, 1'b0);
    repeat (3) @(negedge clk);
    echo[id] = 1'b1;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    echo[id] = 1'b0;
    wait_drain(400);
    trig_seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (trigger != '0) trig_seen++;
    end
    chk("park_no_trigger", trig_seen, 0);
    chk("park_crash_hold", crash_vec, crash_m);

    // reset pulsed mid-trigger: everything clears at once, no result
    enable = 1'b1;
    wait_trig_rise(1000);
    repeat (4) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("midtrig_rst_trigger", trigger, 0);
    chk("midtrig_rst_cycles", result_cycles, 0);
    chk("midtrig_rst_id", result_id, 0);
    chk("midtrig_rst_valid", result_valid, 0);
    chk("midtrig_rst_timeout", result_timeout, 0);
    chk("midtrig_rst_crash_vec", crash_vec, 0);
    chk("midtrig_rst_is_crash", is_crash, 0);
    crash_m = '0;
    hist_m  = '0;
    next_id = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    trig_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (trigger != '0 || result_valid) trig_seen++;
    end
    chk("post_rst_quiet", trig_seen, 0);

    enable = 1'b1;
    ping(80, 80, 1'b0);
    wait_drain(400);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
